ccff_chain_loader: RTL and testbench

- Initiator end of the configuration-chain protocol. Drives ccff_head and a shift-enable into a tile's serial configuration flip-flop chain, and samples ccff_tail at the far end.
- Accepts bitstream words over a valid/ready stream and serialises them MSB-first, one bit per shifting prog_clk cycle, until exactly CHAIN_LEN bits have been shifted.
- Sits between the programming controller and the first ccff_head of a tile column.

---
 rtl/ccff_chain_loader.sv | 185 ++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain initiator: serialises bitstream words MSB-first into a ccff chain.
// Define CCFF_READBACK_EN to capture ccff_tail into a readback word stream (rb_*).

module ccff_chain_loader #(
  parameter int  CHAIN_LEN = 88,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
`ifdef CCFF_READBACK_EN
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
`endif
  output logic              busy,
  output logic              done
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int PW     = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [PW-1:0]     sr_cnt_q, sr_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;

  logic [CNT_W:0]    issued;
  logic              more, accept, rb_block, load_fin;

  // bits already committed to the chain, including the one on ccff_head now
  assign issued  = {1'b0, bit_cnt_q} + {{CNT_W{1'b0}}, shift_en_q};
  assign more    = issued < (CNT_W+1)'(CHAIN_LEN);
  assign s_ready = (state_q == LOAD) && (sr_cnt_q == '0) &&
                   (wcnt_q < WC_W'(NWORDS)) && !rb_block;
  assign accept  = s_valid && s_ready;

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] cap_q, cap_d, rb_data_q, rb_data_d, cap_nxt;
  logic [PW-1:0]     cap_cnt_q, cap_cnt_d, pos_nxt;
  logic              rb_valid_q, rb_valid_d;
  logic              cap_done, rb_pend_nxt, next_completes;

  assign cap_nxt  = (cap_q << 1) | WORD_W'(ccff_tail);
  assign cap_done = shift_en_q && ((cap_cnt_q == PW'(WORD_W-1)) ||
                                   (bit_cnt_q == CNT_W'(CHAIN_LEN-1)));
  // Capture position of the bit we would issue next; stall if it would
  // complete a word while the previous readback word is still unaccepted.
  assign pos_nxt  = (shift_en_q && (cap_cnt_q == PW'(WORD_W-1))) ? '0
                    : cap_cnt_q + PW'(shift_en_q);
  assign next_completes = (pos_nxt == PW'(WORD_W-1)) ||
                          (issued == (CNT_W+1)'(CHAIN_LEN-1));
  assign rb_pend_nxt = (rb_valid_q && !rb_ready) || cap_done;
  assign rb_block    = rb_pend_nxt && next_completes;
  assign load_fin    = (bit_cnt_q == CNT_W'(CHAIN_LEN)) && rb_valid_q && rb_ready;

  always_comb begin
    cap_d      = cap_q;
    cap_cnt_d  = cap_cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = rb_valid_q;
    if (rb_valid_q && rb_ready) rb_valid_d = 1'b0;
    if (cap_done) begin
      cap_d      = '0;
      cap_cnt_d  = '0;
      rb_data_d  = cap_nxt << (PW'(WORD_W-1) - cap_cnt_q);
      rb_valid_d = 1'b1;
    end else if (shift_en_q) begin
      cap_d     = cap_nxt;
      cap_cnt_d = cap_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      cap_q      <= '0;
      cap_cnt_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      cap_cnt_q  <= cap_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_block    = 1'b0;
  assign load_fin    = shift_en_q && (bit_cnt_q == CNT_W'(CHAIN_LEN-1));
`endif

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    sr_cnt_d   = sr_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    wcnt_d     = wcnt_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        head_d = 1'b0;
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          wcnt_d    = '0;
          sr_cnt_d  = '0;
        end
      end
      LOAD: begin
        if (shift_en_q) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (accept) wcnt_d = wcnt_q + WC_W'(1);
        if (more && !rb_block) begin
          if (accept) begin
            head_d     = s_data[WORD_W-1];
            sr_d       = s_data << 1;
            sr_cnt_d   = PW'(WORD_W-1);
            shift_en_d = 1'b1;
          end else if (sr_cnt_q != '0) begin
            head_d     = sr_q[WORD_W-1];
            sr_d       = sr_q << 1;
            sr_cnt_d   = sr_cnt_q - PW'(1);
            shift_en_d = 1'b1;
          end
        end
        // leftover low bits of the final word are dropped here
        if (load_fin) begin
          state_d    = DONE;
          head_d     = 1'b0;
          shift_en_d = 1'b0;
          sr_cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        head_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      sr_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      wcnt_q     <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      sr_cnt_q   <= sr_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      wcnt_q     <= wcnt_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = (state_q == LOAD);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader (CHAIN_LEN=10, WORD_W=4) with a serial chain model.
module tb_ccff_chain_loader;
  localparam int CL = 10;
  localparam int W  = 4;
`ifdef CCFF_READBACK_EN
  localparam int DONE_LAT = 2;
`else
  localparam int DONE_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready, head, shift_en, tail, busy, done;
  logic [CL-1:0] chain = '0;
  logic         preload = 1'b0;
`ifdef CCFF_READBACK_EN
  logic [W-1:0] rb_data;
  logic         rb_valid;
  logic         rb_ready = 1'b1;
`endif

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(head), .ccff_shift_en(shift_en), .ccff_tail(tail),
`ifdef CCFF_READBACK_EN
    .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
`endif
    .busy(busy), .done(done)
  );

  // downstream chain: oldest bit appears on tail
  assign tail = chain[CL-1];
  always @(posedge clk) begin
    if (preload) chain <= '1;
    else if (shift_en) chain <= {chain[CL-2:0], head};
  end

  int total = 0, bad = 0, cyc = 0;
  int load_id = 0, mon_id = 0;
  int shifts = 0, gaps = 0, last_shift_cyc = 0, done_cyc = 0;
  bit done_seen = 0, prev_done = 0;
  logic prev_head = 1'b0;
  bit exp_q[$];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops expected head bits on every shift cycle
  always @(negedge clk) begin
    cyc++;
    if (load_id != mon_id) begin
      mon_id = load_id; shifts = 0; gaps = 0; done_seen = 0;
    end
    if (!rst_n) begin
      prev_head = 1'b0; prev_done = 0;
    end else begin
      if (shift_en) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL head_unexpected: shift with empty queue at cycle %0d", cyc);
        end else chk("head", head, exp_q.pop_front());
        shifts++; last_shift_cyc = cyc;
      end else if (busy && shifts > 0 && shifts < CL) begin
        gaps++;
        chk("head_hold", head, prev_head);
      end
      if (done) begin
        chk("done_shifts", shifts, CL);
        chk("done_latency", cyc - last_shift_cyc, DONE_LAT);
        chk("done_width", prev_done, 0);
        chk("exp_left", exp_q.size(), 0);
        done_seen = 1; done_cyc = cyc;
      end
      prev_head = head; prev_done = done;
    end
  end

`ifdef CCFF_READBACK_EN
  logic [W-1:0] rb_exp[$];
  logic [W-1:0] rb_hold = '0;
  bit rb_on = 0, rb_pend = 0;
  int rb_last_cyc = 0;
  always @(negedge clk) begin
    if (rst_n && rb_on) begin
      if (rb_valid && !rb_pend) begin
        if (rb_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rb_unexpected: rb word %0h with empty queue", rb_data);
        end else chk("rb_data", rb_data, rb_exp.pop_front());
        rb_pend = 1; rb_hold = rb_data;
      end else if (rb_valid) chk("rb_stable", rb_data, rb_hold);
      if (rb_valid && rb_ready) begin
        rb_pend = 0; rb_last_cyc = cyc;
      end
    end
  end
`endif

  task automatic push_bits(input logic [W-1:0] w, input int n);
    logic [W-1:0] t;
    t = w;
    for (int i = 0; i < n; i++) exp_q.push_back(t[W-1-i]);
  endtask

  task automatic new_load();
    load_id++;
    @(negedge clk); #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] w);
    bit ok;
    ok = 0;
    s_data = w; s_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: word %0h not accepted", w);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !done_seen; i++) begin
      @(negedge clk); #1;
      chk("s_ready_after_last", s_ready, 0);
    end
    if (!done_seen) begin
      total++; bad++;
      $display("FAIL done_timeout: done never pulsed");
    end
    @(negedge clk); #1;
    chk("post_busy", busy, 0);
    chk("post_s_ready", s_ready, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_head", head, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_done", done, 0);
`ifdef CCFF_READBACK_EN
    chk("rst_rb_valid", rb_valid, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // streamed load, s_valid held high; third word's low bits dropped
    new_load();
    push_bits(4'hA, 4); push_bits(4'h5, 4); push_bits(4'hC, 2);
    s_data = 4'hA; s_valid = 1'b1;
    pulse_start();
    send(4'hA); send(4'h5); send(4'hC);
    s_data = 4'hF;
    wait_done();
    chk("t1_gaps", gaps, 0);
    s_valid = 1'b0;

    // 3-cycle s_valid gap after the first word drains
    new_load();
    push_bits(4'hA, 4); push_bits(4'h5, 4); push_bits(4'hC, 2);
    s_data = 4'hA; s_valid = 1'b1;
    pulse_start();
    send(4'hA);
    s_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    repeat (3) @(posedge clk);
    #1;
    send(4'h5); send(4'hC);
    s_valid = 1'b0;
    wait_done();
    chk("t2_gaps", gaps, 3);

    // s_valid while IDLE is ignored; start during LOAD is ignored
    s_data = 4'hA; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("idle_s_ready", s_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_shift_en", shift_en, 0);
    end
    new_load();
    push_bits(4'hA, 4); push_bits(4'h5, 4); push_bits(4'hC, 2);
    pulse_start();
    send(4'hA);
    s_data = 4'h5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("restart_busy", busy, 1);
    send(4'h5); send(4'hC);
    s_valid = 1'b0;
    wait_done();

    // reset after 5 shifts, then a clean reload from count 0
    new_load();
    push_bits(4'hA, 4); push_bits(4'h5, 4); push_bits(4'hC, 2);
    s_data = 4'hA; s_valid = 1'b1;
    pulse_start();
    send(4'hA); send(4'h5);
    s_valid = 1'b0;
    for (int i = 0; i < 30 && shifts < 5; i++) begin
      @(negedge clk); #1;
    end
    chk("pre_reset_shifts", shifts, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_shift_en", shift_en, 0);
    chk("mid_rst_head", head, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    new_load();
    push_bits(4'hA, 4); push_bits(4'h5, 4); push_bits(4'hC, 2);
    s_data = 4'hA; s_valid = 1'b1;
    pulse_start();
    send(4'hA); send(4'h5); send(4'hC);
    s_valid = 1'b0;
    wait_done();

`ifdef CCFF_READBACK_EN
    // readback of a preloaded all-ones chain with rb_ready held low
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    rb_ready = 1'b0; rb_on = 1;
    rb_exp.push_back(4'hF); rb_exp.push_back(4'hF); rb_exp.push_back(4'hC);
    new_load();
    push_bits(4'h0, 4); push_bits(4'h0, 4); push_bits(4'h0, 2);
    s_data = 4'h0; s_valid = 1'b1;
    pulse_start();
    send(4'h0); send(4'h0);
    repeat (12) @(negedge clk);
    #1;
    chk("rb_stall_shifts", shifts, 7);
    chk("rb_stall_no_done", done_seen, 0);
    @(posedge clk); #1 rb_ready = 1'b1;
    send(4'h0);
    s_valid = 1'b0;
    wait_done();
    chk("done_after_rb", (done_cyc > rb_last_cyc) ? 1 : 0, 1);
    chk("rb_left", rb_exp.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
